lut_loader: RTL and testbench

LUT_LOADER -- requirements
Module: lut_loader

---
 rtl/lut_loader_pkg.sv | 48 ++++
 rtl/lut_loader_mod_mul_serial.sv | 68 ++++++
 rtl/lut_loader.sv | 181 ++++++++++++++++++
 tb/tb_lut_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_loader_pkg                                                       |
// | Shared constants, FSM encoding and mod-p helpers for lut_loader.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lut_loader_pkg;

   localparam int COORD_W   = 255;
   localparam int WORD_W    = 64;
   localparam int MUL_STEPS = 255;

   // p = 2^255 - 19
   localparam logic [COORD_W-1:0] P_MOD   = {COORD_W{1'b1}} - 255'd18;
   localparam logic [255:0]       D_FULL  =
      256'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3;
   localparam logic [COORD_W-1:0] D_CONST = D_FULL[COORD_W-1:0];

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ADDSUB = 3'd2,
      ST_MUL_XY = 3'd3,
      ST_MUL_D  = 3'd4,
      ST_WRITE  = 3'd5
   } state_t;

   function automatic logic [COORD_W-1:0] reduce_p(input logic [COORD_W-1:0] v);
      return (v >= P_MOD) ? v - P_MOD : v;
   endfunction

   // Both operands must already be < p.
   function automatic logic [COORD_W-1:0] add_mod(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
      logic [COORD_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P_MOD})
         s = s - {1'b0, P_MOD};
      return s[COORD_W-1:0];
   endfunction

   function automatic logic [COORD_W-1:0] sub_mod(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
      return (a >= b) ? a - b : a - b + P_MOD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lut_loader_mod_mul_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_mul_serial                                                       |
// | Bit-serial MSB-first modular multiplier, 255 cycles from start.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mod_mul_serial
   import lut_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [COORD_W-1:0] i_op_a,
   input  logic [COORD_W-1:0] i_op_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [COORD_W-1:0] o_result
);

   logic               r_busy;
   logic [7:0]         r_cnt;
   logic [COORD_W-1:0] r_acc;
   logic [COORD_W-1:0] r_a;
   logic [COORD_W-1:0] r_b;

   logic [COORD_W-1:0] w_acc_in;
   logic [COORD_W-1:0] w_a;
   logic               w_bit;
   logic [COORD_W-1:0] w_acc_next;

   // The start cycle already performs the first step, so the product is
   // complete after exactly MUL_STEPS cycles.
   always_comb begin
      w_acc_in   = r_busy ? r_acc : '0;
      w_a        = r_busy ? r_a : i_op_a;
      w_bit      = r_busy ? r_b[COORD_W-1] : i_op_b[COORD_W-1];
      w_acc_next = add_mod(add_mod(w_acc_in, w_acc_in), w_bit ? w_a : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_a    <= '0;
         r_b    <= '0;
      end else if (r_busy) begin
         r_acc <= w_acc_next;
         r_b   <= r_b << 1;
         if (r_cnt == 8'd0)
            r_busy <= 1'b0;
         else
            r_cnt <= r_cnt - 8'd1;
      end else if (i_start) begin
         r_acc  <= w_acc_next;
         r_a    <= i_op_a;
         r_b    <= i_op_b << 1;
         r_cnt  <= 8'(MUL_STEPS - 2);
         r_busy <= 1'b1;
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_busy && (r_cnt == 8'd0);
   assign o_result = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/lut_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_loader                                                           |
// | Loads an (x,y) point in 8 words and writes X/Y/Z/T LUT entries.      |
// | Option LUT_PRECALC_EN: write (y-x, y+x, 1, x*y*d) instead of         |
// | (x, y, 1, x*y).                                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lut_loader
   import lut_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_in_valid,
   input  logic [WORD_W-1:0]  i_in_data,
   output logic               o_in_ready,
   output logic [COORD_W-1:0] X_in_data,
   output logic [COORD_W-1:0] Y_in_data,
   output logic [COORD_W-1:0] Z_in_data,
   output logic [COORD_W-1:0] T_in_data,
   output logic               X_we,
   output logic               Y_we,
   output logic               Z_we,
   output logic               T_we,
   output logic               o_busy,
   output logic               o_done
);

   state_t             r_state;
   state_t             w_state_next;
   logic [2:0]         r_cnt;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [COORD_W-1:0] r_x_out;
   logic [COORD_W-1:0] r_y_out;
   logic [COORD_W-1:0] r_t_out;
`ifdef LUT_PRECALC_EN
   logic [COORD_W-1:0] r_a2;
   logic [COORD_W-1:0] r_b2;
   logic [COORD_W-1:0] r_t;
`endif

   logic               w_accept;
   logic               w_we;
   logic               w_mul_start;
   logic [COORD_W-1:0] w_mul_a;
   logic [COORD_W-1:0] w_mul_b;
   logic               w_mul_busy;
   logic               w_mul_done;
   logic [COORD_W-1:0] w_mul_result;

   mod_mul_serial u_mul (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_mul_start),
      .i_op_a   (w_mul_a),
      .i_op_b   (w_mul_b),
      .o_busy   (w_mul_busy),
      .o_done   (w_mul_done),
      .o_result (w_mul_result)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      o_in_ready   = (r_state == ST_IDLE) || (r_state == ST_LOAD);
      o_busy       = (r_state != ST_IDLE);
      w_we         = (r_state == ST_WRITE);
      w_accept     = i_in_valid && o_in_ready;
      w_mul_start  = 1'b0;
      w_mul_a      = r_x;
      w_mul_b      = r_y;

      case (r_state)
         ST_IDLE: begin
            if (w_accept)
               w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_accept && (r_cnt == 3'd7))
`ifdef LUT_PRECALC_EN
               w_state_next = ST_ADDSUB;
`else
               w_state_next = ST_MUL_XY;
`endif
         end
`ifdef LUT_PRECALC_EN
         ST_ADDSUB: w_state_next = ST_MUL_XY;
`endif
         ST_MUL_XY: begin
            w_mul_start = !w_mul_busy;
            if (w_mul_done)
`ifdef LUT_PRECALC_EN
               w_state_next = ST_MUL_D;
`else
               w_state_next = ST_WRITE;
`endif
         end
`ifdef LUT_PRECALC_EN
         ST_MUL_D: begin
            w_mul_start = !w_mul_busy;
            w_mul_a     = r_t;
            w_mul_b     = D_CONST;
            if (w_mul_done)
               w_state_next = ST_WRITE;
         end
`endif
         ST_WRITE: w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_x_out <= '0;
         r_y_out <= '0;
         r_t_out <= '0;
`ifdef LUT_PRECALC_EN
         r_a2    <= '0;
         r_b2    <= '0;
         r_t     <= '0;
`endif
      end else begin
         // Counter wraps from 7 back to 0, ready for the next point.
         if (w_accept) begin
            r_cnt <= r_cnt + 3'd1;
            case (r_cnt)
               3'd0: r_x[63:0]    <= i_in_data;
               3'd1: r_x[127:64]  <= i_in_data;
               3'd2: r_x[191:128] <= i_in_data;
               3'd3: r_x          <= reduce_p({i_in_data[62:0], r_x[191:0]});
               3'd4: r_y[63:0]    <= i_in_data;
               3'd5: r_y[127:64]  <= i_in_data;
               3'd6: r_y[191:128] <= i_in_data;
               default: r_y       <= reduce_p({i_in_data[62:0], r_y[191:0]});
            endcase
         end

`ifdef LUT_PRECALC_EN
         if (r_state == ST_ADDSUB) begin
            r_a2 <= sub_mod(r_y, r_x);
            r_b2 <= add_mod(r_y, r_x);
         end
         if ((r_state == ST_MUL_XY) && w_mul_done)
            r_t <= w_mul_result;
         if ((r_state == ST_MUL_D) && w_mul_done) begin
            r_x_out <= r_a2;
            r_y_out <= r_b2;
            r_t_out <= w_mul_result;
         end
`else
         if ((r_state == ST_MUL_XY) && w_mul_done) begin
            r_x_out <= r_x;
            r_y_out <= r_y;
            r_t_out <= w_mul_result;
         end
`endif
      end
   end

   assign X_in_data = r_x_out;
   assign Y_in_data = r_y_out;
   assign Z_in_data = COORD_W'(1);
   assign T_in_data = r_t_out;
   assign X_we      = w_we;
   assign Y_we      = w_we;
   assign Z_we      = w_we;
   assign T_we      = w_we;
   assign o_done    = w_we;

endmodule
`default_nettype wire

// File: tb/tb_lut_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lut_loader                                                        |
// | Randomized scoreboard bench for lut_loader (honours LUT_PRECALC_EN). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lut_loader;

   localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
   localparam logic [255:0] D =
      256'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3;
`ifdef LUT_PRECALC_EN
   localparam int LAT     = 512;
   localparam int MUL_OFF = 2;
`else
   localparam int LAT     = 256;
   localparam int MUL_OFF = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [63:0]  in_data;
   logic         in_ready;
   logic [254:0] x_d, y_d, z_d, t_d;
   logic         x_we, y_we, z_we, t_we;
   logic         busy, done;

   lut_loader dut (
      .clk        (clk),
      .rst        (rst),
      .i_in_valid (in_valid),
      .i_in_data  (in_data),
      .o_in_ready (in_ready),
      .X_in_data  (x_d),
      .Y_in_data  (y_d),
      .Z_in_data  (z_d),
      .T_in_data  (t_d),
      .X_we       (x_we),
      .Y_we       (y_we),
      .Z_we       (z_we),
      .T_we       (t_we),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [255:0] x, y, z, t;
      int unsigned  due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int unsigned last_xfer = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] prod;
      logic [511:0] rem;
      prod = {256'd0, a} * {256'd0, b};
      rem  = prod % {256'd0, P};
      return rem[255:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++)
         v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic exp_t model(input logic [255:0] xr, input logic [255:0] yr);
      exp_t         e;
      logic [255:0] x, y;
      x = {1'b0, xr[254:0]};
      y = {1'b0, yr[254:0]};
      if (x >= P) x = x - P;
      if (y >= P) y = y - P;
`ifdef LUT_PRECALC_EN
      e.x = (y + P - x) % P;
      e.y = (x + y) % P;
      e.t = mulmod(mulmod(x, y), D);
`else
      e.x = x;
      e.y = y;
      e.t = mulmod(x, y);
`endif
      e.z   = 256'd1;
      e.due = 0;
      return e;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_x"},     x_d, 0);
      check({tag, "_y"},     y_d, 0);
      check({tag, "_z"},     z_d, 1);
      check({tag, "_t"},     t_d, 0);
      check({tag, "_we"},    {x_we, y_we, z_we, t_we, done}, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_ready"}, in_ready, 1);
   endtask

   // Drives one 8-word point; optional 1/0 valid toggling and words offered while busy.
   task automatic send(input logic [255:0] xr, input logic [255:0] yr,
                       input bit gappy, input int hold_busy);
      logic [63:0] w [8];
      int          idx;
      int          guard;
      bit          ph;
      exp_t        e;
      for (int k = 0; k < 4; k++) begin
         w[k]   = xr[k*64 +: 64];
         w[k+4] = yr[k*64 +: 64];
      end
      idx = 0; guard = 0; ph = 1'b0;
      while (idx < 8 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (gappy && ph) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
         end else begin
            in_valid = 1'b1;
            in_data  = w[idx];
            if (in_ready) begin
               if (idx == 7) begin
                  e         = model(xr, yr);
                  e.due     = cyc + LAT;
                  last_xfer = cyc;
                  sb.push_back(e);
               end
               idx++;
            end
         end
         ph = ~ph;
      end
      check("load_words_accepted", idx, 8);
      for (int k = 0; k < hold_busy; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         check("ready_low_while_busy", in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < LAT + 100) begin
         @(negedge clk);
         guard++;
      end
      check("completion_within_bound", (sb.size() == 0), 1);
      sb.delete();
   endtask

   always @(negedge clk) begin
      if (!rst && (x_we || y_we || z_we || t_we || done)) begin
         check("we_done_together", {x_we, y_we, z_we, t_we, done}, 5'b11111);
         check("write_was_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("X_data",  x_d, mon_e.x);
            check("Y_data",  y_d, mon_e.y);
            check("Z_data",  z_d, mon_e.z);
            check("T_data",  t_d, mon_e.t);
            check("latency", cyc, mon_e.due);
         end
      end
   end

   initial begin
      logic [255:0] a, b;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");

      send(256'd0, 256'd1, 1'b0, 0);   wait_done();
      send(256'd1, 256'd2, 1'b0, 0);   wait_done();
      send(P - 256'd1, 256'd0, 1'b0, 0); wait_done();
      send(P, 256'd5, 1'b0, 20);       wait_done();
      // Bit 255 set in both: must be discarded, then y == p reduces to 0.
      a = '1;
      b = P | (256'd1 << 255);
      send(a, b, 1'b1, 0);             wait_done();

      for (int n = 0; n < 6; n++) begin
         a = rand256();
         b = rand256();
         send(a, b, 1'b0, 0);                        wait_done();
         send(a, b, 1'b1, int'($urandom_range(0, 30))); wait_done();
      end

      // Abort 100 cycles into MUL_XY.
      a = rand256();
      b = rand256();
      send(a, b, 1'b0, 0);
      while (cyc < last_xfer + MUL_OFF + 100) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("abort");
      repeat (LAT + 20) @(negedge clk);
      check("abort_no_write", x_d, 0);
      send(b, a, 1'b0, 0);             wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
